// File: rtl/char_pkg.sv
// Shared constants and types for the character-memory arbiter.
// Address/data widths, response-state encoding and starvation helpers.
package char_pkg;

    localparam int CHAR_ADDR_W = 15;
    localparam int CHAR_DATA_W = 8;
    localparam int STARVE_W = 4;
    localparam int STARVE_LIMIT_DEF = 8;

    // Which requester, if any, owns the response cycle.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RESP_VGA = 2'd1,
        ST_RESP_CPU = 2'd2
    } arb_state_t;

    // Saturating increment for the starvation counter.
    function automatic logic [STARVE_W-1:0] sat_inc(
        input logic [STARVE_W-1:0] v,
        input logic [STARVE_W-1:0] lim
    );
        return (v >= lim) ? lim : v + 1'b1;
    endfunction

endpackage

// File: rtl/char_mode.sv
// Address/data select mux for the character memory port.
// mode=1 selects the CPU side, mode=0 the VGA side; idle port drives zero.
module char_mode
    import char_pkg::*;
(
    input  logic                   en,
    input  logic                   mode,
    input  logic [CHAR_ADDR_W-1:0] vga_addr,
    input  logic [CHAR_ADDR_W-1:0] cpu_addr,
    input  logic                   cpu_we,
    input  logic [CHAR_DATA_W-1:0] cpu_wdata,
    output logic [CHAR_ADDR_W-1:0] addr,
    output logic                   we,
    output logic [CHAR_DATA_W-1:0] wdata
);

    // Route the owner's address/control to the memory port.
    always_comb begin
        addr  = '0;
        we    = 1'b0;
        wdata = '0;
        if (en) begin
            if (mode) begin
                addr  = cpu_addr;
                we    = cpu_we;
                wdata = cpu_wdata;
            end else begin
                addr  = vga_addr;
            end
        end
    end

endmodule

// File: rtl/char_mem_arbiter.sv
// Single-port character memory arbiter between VGA fetch and CPU access.
// VGA wins by default; a waiting CPU is forced in after STARVE_LIMIT VGA grants.
module char_mem_arbiter
    import char_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   vga_req,
    input  logic [CHAR_ADDR_W-1:0] vga_addr,
    output logic                   vga_gnt,
    output logic                   vga_valid,
    output logic [CHAR_DATA_W-1:0] vga_rdata,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [CHAR_ADDR_W-1:0] cpu_addr,
    input  logic [CHAR_DATA_W-1:0] cpu_wdata,
    output logic                   cpu_ack,
    output logic [CHAR_DATA_W-1:0] cpu_rdata,
    output logic                   mode,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [CHAR_ADDR_W-1:0] mem_addr,
    output logic [CHAR_DATA_W-1:0] mem_wdata,
    input  logic [CHAR_DATA_W-1:0] mem_rdata
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    arb_state_t           state_q;
    arb_state_t           state_d;
    logic                 cpu_busy;
    logic [STARVE_W-1:0]  starve_cnt;
    logic                 cpu_elig;
    logic                 at_limit;
    logic                 cpu_gnt;

    // Pick at most one owner for this issue cycle.
    always_comb begin
        cpu_elig = cpu_req & ~cpu_busy;
        at_limit = (starve_cnt == LIMIT);
        cpu_gnt  = ~rst & cpu_elig & (~vga_req | at_limit);
        vga_gnt  = ~rst & vga_req & ~cpu_gnt;
        mode     = cpu_gnt;
        mem_en   = vga_gnt | cpu_gnt;
    end

    char_mode u_mode (
        .en        (mem_en),
        .mode      (mode),
        .vga_addr  (vga_addr),
        .cpu_addr  (cpu_addr),
        .cpu_we    (cpu_we),
        .cpu_wdata (cpu_wdata),
        .addr      (mem_addr),
        .we        (mem_we),
        .wdata     (mem_wdata)
    );

    // Next response owner follows the current grant.
    always_comb begin
        state_d = ST_IDLE;
        unique case (1'b1)
            cpu_gnt: state_d = ST_RESP_CPU;
            vga_gnt: state_d = ST_RESP_VGA;
            default: state_d = ST_IDLE;
        endcase
    end

    // Response owner tag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A granted CPU request stays blocked until it is withdrawn after its
    // ack, so a held request is never issued twice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_busy <= 1'b0;
        end else begin
            cpu_busy <= cpu_gnt | (cpu_busy & cpu_req);
        end
    end

    // Count VGA grants taken while the CPU is kept waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (cpu_gnt || !cpu_elig) begin
            starve_cnt <= '0;
        end else if (vga_gnt) begin
            starve_cnt <= sat_inc(starve_cnt, LIMIT);
        end
    end

    // Route synchronous read data to the owner of the response cycle.
    always_comb begin
        vga_valid = (state_q == ST_RESP_VGA);
        cpu_ack   = (state_q == ST_RESP_CPU);
        vga_rdata = vga_valid ? mem_rdata : '0;
        cpu_rdata = cpu_ack ? mem_rdata : '0;
    end

endmodule

// File: doc/char_mem_arbiter.md
CHAR_MEM_ARBITER -- requirements
Module: char_mem_arbiter

Interface
REQ-001 The module SHALL have one parameter: STARVE_LIMIT, default 8, the number of consecutive VGA grants allowed while a CPU request waits (range 1..15).
REQ-002 clk  input  1  single clock for all sequential logic.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 vga_req  input  1  VGA character fetch request; held high until vga_gnt.
REQ-005 vga_addr  input  15  VGA character address.
REQ-006 vga_gnt  output  1  VGA request accepted this cycle.
REQ-007 vga_valid  output  1  vga_rdata valid; pulses one cycle after vga_gnt.
REQ-008 vga_rdata  output  8  VGA read data.
REQ-009 cpu_req  input  1  CPU access request; held stable until cpu_ack.
REQ-010 cpu_we  input  1  CPU write (1) or read (0).
REQ-011 cpu_addr  input  15  CPU character address.
REQ-012 cpu_wdata  input  8  CPU write data.
REQ-013 cpu_ack  output  1  CPU access complete; cpu_rdata valid on reads.
REQ-014 cpu_rdata  output  8  CPU read data.
REQ-015 mode  output  1  1 = CPU owns the memory port this cycle, 0 = VGA (same encoding as the existing address-select mux).
REQ-016 mem_en, mem_we  output  1 each  memory port enable and write enable.
REQ-017 mem_addr  output  15  memory address; mem_wdata  output  8  memory write data.
REQ-018 mem_rdata  input  8  memory read data, synchronous, one-cycle latency.

Function
REQ-019 Issue cycle N: at most one grant; mem_en=1 iff a grant; mem_addr/mem_we/mem_wdata combinationally select the granted requester; idle port: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-020 Response cycle N+1: a registered owner tag routes mem_rdata to vga_rdata with vga_valid=1, or to cpu_rdata with cpu_ack=1; a CPU write also acks at N+1 (cpu_rdata don't-care).
REQ-021 CPU eligible = cpu_req & ~cpu_busy; cpu_busy set on CPU grant, cleared on cpu_ack, so a held request is never issued twice; new CPU request earliest in the cycle after cpu_ack.
REQ-022 Arbitration: VGA has priority over an eligible CPU unless starve_cnt == STARVE_LIMIT, in which case CPU is granted and vga_gnt=0 (VGA holds).
REQ-023 starve_cnt (4-bit): +1 on each VGA grant while CPU eligible; cleared on CPU grant; cleared when CPU not eligible; saturates at STARVE_LIMIT.
REQ-024 FSM states: IDLE (no response due), RESP_VGA, RESP_CPU; next state = owner of the current grant, or IDLE if none; back-to-back grants allowed every cycle.
REQ-025 Outputs vga_valid, cpu_ack, vga_rdata, cpu_rdata are driven from registered state only; vga_gnt, mode, mem_* are combinational from requests and registers.
REQ-026 cpu_req dropped without ack while not busy: no access; dropping while busy is illegal (bench asserts).

Reset
REQ-027 rst asynchronously forces state=IDLE, cpu_busy=0, starve_cnt=0, vga_valid=0, cpu_ack=0, vga_rdata=0, cpu_rdata=0.
REQ-028 Reset mid-access: no vga_valid or cpu_ack is produced for the aborted access; a write already issued to memory is not undone.
REQ-029 While rst is high, no grant, mem_en=0, mode=0.

Structure
REQ-030 The shared package (char_pkg) SHALL hold CHAR_ADDR_W=15, CHAR_DATA_W=8, the state encodings, and the STARVE_LIMIT default.
REQ-031 The address/data selection SHALL reuse the existing char_mode mux as the one sub-module, driven by mode; the remaining logic stays flat.

Verification
REQ-032 VGA only: vga_req held, addresses 0x0000..0x0003 -> vga_gnt every cycle, vga_valid each cycle after with matching memory data, mode=0.
REQ-033 CPU write then read: write 0x1234<-0xA5, then read 0x1234 -> cpu_ack one cycle after each grant, read returns 0xA5, mode=1 on the two issue cycles only.
REQ-034 Contention: vga_req continuous, CPU read pending, STARVE_LIMIT=8 -> 8 VGA grants, then 1 CPU grant with vga_gnt=0, then VGA resumes; starve_cnt back to 0.
REQ-035 Held request: cpu_req held high for 5 cycles with no VGA -> exactly one mem_en for the CPU and one cpu_ack.
REQ-036 Reset mid-access: assert rst the cycle after a CPU read grant -> no cpu_ack, all outputs at reset values, cpu_busy=0 after release.
